// File: rtl/vga_vram_pkg.sv
// Shared types and constants for the text-mode VRAM arbiter: access tags that
// follow each RAM access down the read pipeline, and host FSM states.
package vga_vram_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_HOST
    } acc_tag_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT1,
        ST_WAIT2,
        ST_ACK
    } host_state_e;

    // Cycles from a display slot to its cell_valid pulse.
    localparam int FETCH_LAT = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Host request/response bus into the VRAM arbiter: master is the CPU/loader,
// slave is the arbiter.
interface vga_vram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_rdata;

    modport master (
        output host_req,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_ack,
        input  host_rdata
    );

    modport slave (
        input  host_req,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_ack,
        output host_rdata
    );
endinterface

// File: rtl/vga_text_addr_gen.sv
// Text-cell address generator: tracks the 8-cycle phase within the fetch
// window, the column, and the scanline/row position, and flags display slots.
module vga_text_addr_gen
    import vga_vram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int COLS       = 100,
    parameter int CELL_H     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        fetch_en,
    output logic                        disp_slot,
    output logic [ADDR_WIDTH-1:0]       disp_addr,
    output logic [clog2(CELL_H)-1:0]    font_row
);

    localparam int FR_W  = clog2(CELL_H);
    localparam int COL_W = clog2(COLS + 1);

    logic [2:0]            ph_reg, ph_next;
    logic [COL_W-1:0]      col_reg, col_next;
    logic [FR_W-1:0]       font_row_reg, font_row_next;
    logic [ADDR_WIDTH-1:0] row_base_reg, row_base_next;
    logic                  fetch_en_d_reg;
    logic                  line_end;

    // col saturates at COLS, so an over-long window yields no extra slots.
    assign disp_slot = fetch_en && (ph_reg == 3'd0) && (col_reg < COL_W'(COLS));
    assign disp_addr = row_base_reg + ADDR_WIDTH'(col_reg);
    assign line_end  = fetch_en_d_reg && !fetch_en;
    assign font_row  = font_row_reg;

    always_comb begin
        ph_next       = fetch_en ? (ph_reg + 3'd1) : 3'd0;
        col_next      = col_reg;
        font_row_next = font_row_reg;
        row_base_next = row_base_reg;
        if (frame_start) begin
            col_next      = '0;
            font_row_next = '0;
            row_base_next = '0;
        end else if (line_end) begin
            col_next = '0;
            if (font_row_reg == FR_W'(CELL_H - 1)) begin
                font_row_next = '0;
                row_base_next = row_base_reg + ADDR_WIDTH'(COLS);
            end else begin
                font_row_next = font_row_reg + 1'b1;
            end
        end else if (disp_slot) begin
            col_next = col_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_reg         <= '0;
            col_reg        <= '0;
            font_row_reg   <= '0;
            row_base_reg   <= '0;
            fetch_en_d_reg <= 1'b0;
        end else begin
            ph_reg         <= ph_next;
            col_reg        <= col_next;
            font_row_reg   <= font_row_next;
            row_base_reg   <= row_base_next;
            fetch_en_d_reg <= fetch_en;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns one fixed slot per 8-pixel
// cell, the host gets every other cycle through a 4-state request FSM.
module vga_vram_arbiter
    import vga_vram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 100,
    parameter int CELL_H     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     fetch_en,
    output logic [DATA_WIDTH-1:0]    cell_data,
    output logic                     cell_valid,
    output logic [clog2(CELL_H)-1:0] font_row,
    vga_vram_arbiter_if.slave        hbus,
    output logic [ADDR_WIDTH-1:0]    ram_addr,
    output logic                     ram_we,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    logic                  disp_slot;
    logic [ADDR_WIDTH-1:0] disp_addr;

    host_state_e state_reg, state_next;
    logic        host_grant;

    acc_tag_e              tag_s1_reg, tag_s2_reg;
    logic                  host_write_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic                  ram_we_reg;
    logic [DATA_WIDTH-1:0] ram_wdata_reg;
    logic [DATA_WIDTH-1:0] cell_data_reg;
    logic                  cell_valid_reg;
    logic                  host_ack_reg;
    logic [DATA_WIDTH-1:0] host_rdata_reg;

    vga_text_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COLS       (COLS),
        .CELL_H     (CELL_H)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .fetch_en    (fetch_en),
        .disp_slot   (disp_slot),
        .disp_addr   (disp_addr),
        .font_row    (font_row)
    );

    // A grant is only possible from IDLE, and IDLE is never revisited within
    // 4 cycles, so the host can never own two back-to-back RAM cycles.
    always_comb begin
        state_next = state_reg;
        host_grant = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hbus.host_req && !disp_slot) begin
                    host_grant = 1'b1;
                    state_next = ST_WAIT1;
                end
            end
            ST_WAIT1: state_next = ST_WAIT2;
            ST_WAIT2: state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_s1_reg     <= TAG_NONE;
            tag_s2_reg     <= TAG_NONE;
            host_write_reg <= 1'b0;
            ram_addr_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_wdata_reg  <= '0;
            cell_data_reg  <= '0;
            cell_valid_reg <= 1'b0;
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= '0;
        end else begin
            ram_we_reg <= 1'b0;
            tag_s1_reg <= TAG_NONE;
            if (disp_slot) begin
                ram_addr_reg <= disp_addr;
                tag_s1_reg   <= TAG_DISP;
            end else if (host_grant) begin
                ram_addr_reg   <= hbus.host_addr;
                ram_we_reg     <= hbus.host_we;
                ram_wdata_reg  <= hbus.host_wdata;
                host_write_reg <= hbus.host_we;
                tag_s1_reg     <= TAG_HOST;
            end

            // Tag stage 2 lines up with the RAM's registered read data.
            tag_s2_reg     <= tag_s1_reg;
            cell_valid_reg <= 1'b0;
            if (tag_s2_reg == TAG_DISP) begin
                cell_data_reg  <= ram_rdata;
                cell_valid_reg <= 1'b1;
            end
            if ((tag_s2_reg == TAG_HOST) && !host_write_reg) begin
                host_rdata_reg <= ram_rdata;
            end
            host_ack_reg <= (state_reg == ST_WAIT2);
        end
    end

    assign ram_addr        = ram_addr_reg;
    assign ram_we          = ram_we_reg;
    assign ram_wdata       = ram_wdata_reg;
    assign cell_data       = cell_data_reg;
    assign cell_valid      = cell_valid_reg;
    assign hbus.host_ack   = host_ack_reg;
    assign hbus.host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: stimulus queues expected cell pulses,
// host acks and RAM writes; a negedge monitor pops and compares them.
module tb_vga_vram_arbiter;
    import vga_vram_pkg::*;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int COLS      = 100;
    localparam int CELL_H    = 16;
    localparam int MW        = 10;
    localparam int MEM_DEPTH = 1 << MW;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [3:0]  fr;
    } cell_exp_t;

    typedef struct {
        int          cyc;
        bit          is_read;
        logic [15:0] data;
    } host_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic fetch_en;
    logic [DW-1:0] cell_data;
    logic cell_valid;
    logic [clog2(CELL_H)-1:0] font_row;
    logic [AW-1:0] ram_addr;
    logic ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    vga_vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hbus ();

    vga_vram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .COLS       (COLS),
        .CELL_H     (CELL_H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .fetch_en    (fetch_en),
        .cell_data   (cell_data),
        .cell_valid  (cell_valid),
        .font_row    (font_row),
        .hbus        (hbus),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input int a);
        return 16'h5A00 ^ 16'(a * 7);
    endfunction

    // Synchronous-read RAM, read-old on a same-cycle write.
    logic [DW-1:0] mem [0:MEM_DEPTH-1];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= pat(i);
        end else if (ram_we) begin
            mem[ram_addr[MW-1:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[MW-1:0]];
    end

    logic [15:0] shadow [0:MEM_DEPTH-1];
    cell_exp_t   cell_q [$];
    host_exp_t   host_q [$];
    wr_exp_t     wr_q [$];
    int          checks = 0;
    int          failures = 0;
    int          line_r;
    int          line_len;
    logic [3:0]  exp_fr;
    int          exp_base;

    task automatic report(input bit ok, input string what, input string act, input string req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, expected %s", what, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        report(cell_data === '0, {tag, "_cell_data"}, $sformatf("%h", cell_data), "0");
        report(cell_valid === 1'b0, {tag, "_cell_valid"}, $sformatf("%b", cell_valid), "0");
        report(font_row === '0, {tag, "_font_row"}, $sformatf("%0d", font_row), "0");
        report(hbus.host_ack === 1'b0, {tag, "_host_ack"}, $sformatf("%b", hbus.host_ack), "0");
        report(hbus.host_rdata === '0, {tag, "_host_rdata"}, $sformatf("%h", hbus.host_rdata), "0");
        report(ram_addr === '0, {tag, "_ram_addr"}, $sformatf("%h", ram_addr), "0");
        report(ram_we === 1'b0, {tag, "_ram_we"}, $sformatf("%b", ram_we), "0");
        report(ram_wdata === '0, {tag, "_ram_wdata"}, $sformatf("%h", ram_wdata), "0");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_line(input int len);
        int n;
        line_r   = cyc;
        line_len = len;
        n = (len + 7) / 8;
        if (n > COLS) n = COLS;
        for (int k = 0; k < n; k++) begin
            cell_q.push_back('{cyc: line_r + FETCH_LAT + 8 * k,
                               data: shadow[exp_base + k], fr: exp_fr});
        end
        fetch_en = 1'b1;
    endtask

    task automatic finish_line(input bit with_fs);
        wait_cyc(line_r + line_len);
        fetch_en = 1'b0;
        if (with_fs) begin
            frame_start = 1'b1;
            exp_fr = '0;
            exp_base = 0;
        end else if (exp_fr == 4'(CELL_H - 1)) begin
            exp_fr = '0;
            exp_base = exp_base + COLS;
        end else begin
            exp_fr = exp_fr + 4'd1;
        end
        @(negedge clk);
        frame_start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Called at a negedge; delay is the expected grant deferral in cycles.
    task automatic host_issue(input bit we, input int addr, input logic [15:0] wdata, input int delay);
        int c;
        c = cyc;
        if (we) begin
            wr_q.push_back('{cyc: c + delay + 1, addr: 16'(addr), data: wdata});
            host_q.push_back('{cyc: c + delay + 3, is_read: 1'b0, data: 16'h0});
            shadow[addr] = wdata;
        end else begin
            host_q.push_back('{cyc: c + delay + 3, is_read: 1'b1, data: shadow[addr]});
        end
        hbus.host_req   = 1'b1;
        hbus.host_we    = we;
        hbus.host_addr  = 16'(addr);
        hbus.host_wdata = wdata;
    endtask

    task automatic host_wait_ack();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            @(negedge clk);
            if (hbus.host_ack === 1'b1) hit = 1'b1;
        end
        hbus.host_req = 1'b0;
        hbus.host_we  = 1'b0;
        report(hit, "host_ack_timeout", hit ? "ack" : "no ack", "ack within 16 cycles");
    endtask

    initial begin : monitor
        cell_exp_t ce;
        host_exp_t he;
        wr_exp_t   we_e;
        forever begin
            @(negedge clk);
            if (cell_valid === 1'b1) begin
                if (cell_q.size() == 0) begin
                    report(1'b0, "cell_unexpected",
                           $sformatf("pulse cyc=%0d data=%h", cyc, cell_data), "no pulse");
                end else begin
                    ce = cell_q.pop_front();
                    report(cyc == ce.cyc && cell_data === ce.data && font_row === ce.fr, "cell",
                           $sformatf("cyc=%0d data=%h row=%0d", cyc, cell_data, font_row),
                           $sformatf("cyc=%0d data=%h row=%0d", ce.cyc, ce.data, ce.fr));
                end
            end
            if (hbus.host_ack === 1'b1) begin
                if (host_q.size() == 0) begin
                    report(1'b0, "host_ack_unexpected", $sformatf("ack cyc=%0d", cyc), "no ack");
                end else begin
                    he = host_q.pop_front();
                    report(cyc == he.cyc && (!he.is_read || hbus.host_rdata === he.data), "host_ack",
                           $sformatf("cyc=%0d rdata=%h", cyc, hbus.host_rdata),
                           $sformatf("cyc=%0d rdata=%h read=%0d", he.cyc, he.data, he.is_read));
                end
            end
            if (ram_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    report(1'b0, "ram_we_unexpected",
                           $sformatf("we cyc=%0d addr=%h", cyc, ram_addr), "no write");
                end else begin
                    we_e = wr_q.pop_front();
                    report(cyc == we_e.cyc && ram_addr === we_e.addr && ram_wdata === we_e.data, "ram_write",
                           $sformatf("cyc=%0d addr=%h data=%h", cyc, ram_addr, ram_wdata),
                           $sformatf("cyc=%0d addr=%h data=%h", we_e.cyc, we_e.addr, we_e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset            = 1'b1;
        frame_start      = 1'b0;
        fetch_en         = 1'b0;
        hbus.host_req    = 1'b0;
        hbus.host_we     = 1'b0;
        hbus.host_addr   = '0;
        hbus.host_wdata  = '0;
        mem_init         = 1'b1;
        exp_fr           = '0;
        exp_base         = 0;
        for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = pat(i);

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_zero("por");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Host write then read-back with the display idle.
        host_issue(1'b1, 16'h0005, 16'hBEEF, 0);
        host_wait_ack();
        @(negedge clk);
        host_issue(1'b0, 16'h0005, 16'h0000, 0);
        host_wait_ack();
        repeat (4) @(negedge clk);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);

        // 16 scanlines of row 0, then the first line of row 1.
        for (int l = 0; l < 17; l++) begin
            start_line(800);
            finish_line(1'b0);
        end

        // Host request lands on the slot cycle: deferred one cycle.
        host_issue(1'b1, exp_base + 7, 16'h1234, 1);
        start_line(800);
        host_wait_ack();
        wait_cyc(line_r + 8);
        host_issue(1'b0, exp_base + 7, 16'h0000, 1);
        host_wait_ack();
        finish_line(1'b0);

        // Over-long window: slots past column COLS belong to the host.
        start_line(1000);
        wait_cyc(line_r + 800);
        host_issue(1'b0, 16'h0005, 16'h0000, 0);
        host_wait_ack();
        wait_cyc(line_r + 808);
        host_issue(1'b1, 16'h0300, 16'hCAFE, 0);
        host_wait_ack();
        wait_cyc(line_r + 816);
        host_issue(1'b0, 16'h0300, 16'h0000, 0);
        host_wait_ack();
        finish_line(1'b0);

        // frame_start coinciding with the falling edge of fetch_en wins.
        start_line(64);
        finish_line(1'b1);
        start_line(64);
        finish_line(1'b0);

        // Asynchronous reset in the ph==3 cycle of a fetch window.
        line_r = cyc;
        cell_q.push_back('{cyc: line_r + FETCH_LAT, data: shadow[exp_base], fr: exp_fr});
        fetch_en = 1'b1;
        wait_cyc(line_r + 3);
        #2 reset = 1'b1;
        #1 check_zero("async");
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        exp_fr   = '0;
        exp_base = 0;
        start_line(800);
        finish_line(1'b0);

        repeat (10) @(negedge clk);
        report(cell_q.size() == 0, "cell_queue_drained", $sformatf("%0d left", cell_q.size()), "0 left");
        report(host_q.size() == 0, "host_queue_drained", $sformatf("%0d left", host_q.size()), "0 left");
        report(wr_q.size() == 0, "write_queue_drained", $sformatf("%0d left", wr_q.size()), "0 left");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between two users.
  - Display fetch path: text-mode character cells for the 800x600@72 pipeline.
  - Host port: CPU/loader read-write.
- Sits between `vga_timing_800_600_72` (which supplies `fetch_en`/`frame_start`) and the glyph/pixel stage.
- Display fetch has hard priority on one fixed slot per 8-pixel cell. The host owns every other RAM cycle.

Parameters:
- ADDR_WIDTH, 16, VRAM word address width.
- DATA_WIDTH, 16, VRAM word width (char code + attribute).
- COLS, 100, character cells per text row (800/8).
- CELL_H, 16, scanlines per character row; power of two, 2..32.

Ports:
- clk  in  1  pixel clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse before the first active line of a frame.
- fetch_en  in  1  high for the fetch window of each active line. It rises 8 cycles ahead of display enable and lasts COLS*8 cycles.
- cell_data  out  DATA_WIDTH  fetched cell word.
- cell_valid  out  1  one-cycle pulse; `cell_data` is valid in that cycle.
- font_row  out  log2(CELL_H)  scanline index within the current character row.
- host_req  in  1  host request; held high until `host_ack`.
- host_we  in  1  1 = write, 0 = read; held with `host_req`.
- host_addr  in  ADDR_WIDTH  host word address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_WIDTH  read data, valid when `host_ack` is high (reads only).
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, one cycle after the RAM samples its address.

Behaviour:
- Reset (asynchronous) clears all registers and outputs to 0:
  - outputs: `cell_data`, `cell_valid`, `font_row`, `host_ack`, `host_rdata`, `ram_*`;
  - internal state: `ph`, `col`, `row_base`, `busy`, pipeline tags.
- Reset mid-transaction drops any in-flight request with no ack; the host must re-request.
- Phase counter `ph` (3 bits):
  - 0 while `fetch_en` is low;
  - increments every cycle while `fetch_en` is high, wrapping 7 to 0.
- Display slot = `fetch_en` && `ph`==0 && `col`<COLS. In a display slot:
  - `ram_addr` <= `row_base`+`col` (mod 2^ADDR_WIDTH), `ram_we` <= 0;
  - tag the access as display, then `col`++.
- `col` saturates at COLS. An over-long `fetch_en` window issues no extra fetches, and those slots go to the host.
- Display latency: `cell_valid` pulses exactly 3 cycles after the slot cycle (T):
  - RAM samples the address at the end of T+1;
  - `rdata` appears in T+2 and is registered into `cell_data`;
  - `cell_valid`=1 in T+3.
  - `cell_data` holds its value until the next fetch.
- Host arbiter states:
  - IDLE: grant if `host_req` && !display slot. On grant:
    - `ram_addr` <= `host_addr`, `ram_we` <= `host_we`, `ram_wdata` <= `host_wdata`;
    - go to WAIT1.
    - If `host_req` arrives in a display slot, grant is deferred exactly one cycle.
  - WAIT1: RAM samples the access; go to WAIT2.
  - WAIT2: capture `ram_rdata` into `host_rdata` (reads only); go to ACK.
  - ACK: `host_ack`=1 for one cycle; go to IDLE. The earliest next grant is the cycle after ACK.
  - `ram_we` is high for exactly one cycle per write grant.
- Only one outstanding host access at a time. Host requests are never granted in consecutive cycles, so a display slot never collides with a host access.
- Write/read ordering: a host write to address A granted before a display slot reading A is visible to that read.
- Line/row sequencing, on the falling edge of `fetch_en`:
  - `col` <= 0;
  - if `font_row`==CELL_H-1: `font_row` <= 0 and `row_base` += COLS (mod 2^ADDR_WIDTH);
  - otherwise `font_row`++.
- `frame_start` clears `col`, `font_row` and `row_base`. If it coincides with a `fetch_en` falling edge, `frame_start` wins.
- `host_*` inputs are don't-care while `host_req`=0.

Decomposition:
- Shared package `vga_vram_pkg`:
  - access-tag enum {NONE, DISP, HOST};
  - host FSM state enum {IDLE, WAIT1, WAIT2, ACK};
  - FETCH_LAT=3;
  - `clog2` helper for `font_row` width.
- One natural sub-module: `vga_text_addr_gen`, which holds `ph`/`col`/`font_row`/`row_base` and emits slot + address. The top level holds the host FSM and the RAM muxing.

Test Plan:
- Reset asserted mid-fetch (`fetch_en`=1, `ph`=3) -> all outputs 0 immediately (async); after release, first slot reads addr 0.
- `frame_start`, then a `fetch_en` window of 800 cycles -> exactly 100 `cell_valid` pulses.
  - Pulses at cycles 3, 11, ..., 795 after the rise, addresses 0..99.
  - `font_row`=0.
- 16 line windows then a 17th -> `font_row` 0..15, then wraps to 0; 17th line addresses 100..199.
- `host_req` write (addr 0x0005, data 0xBEEF) with no `fetch_en` -> `ram_we`=1 one cycle after request; `host_ack` 3 cycles after grant.
  - Then a host read of 0x0005 -> `host_rdata`=0xBEEF with `host_ack`.
- `host_req` raised in the `ph`==0 slot cycle -> display address issued that cycle, host granted the next cycle; both complete; `cell_valid` timing unchanged.
- `fetch_en` held 1000 cycles -> only 100 display fetches; host requests in the slots after col 100 are granted without deferral.
